reg_file: RTL and testbench

- 32-entry by 32-bit integer register file for the single-cycle RISC core.
- Sits directly upstream of the ALU: the two asynchronous read ports drive ALU operands A and B.
- One synchronous write port takes writeback data (ALU_Out or load data).
- A post-reset clear sequencer zeroes the array one entry per cycle and holds `busy` high so the core stalls until the array is clean.

---
 rtl/reg_file.sv | 99 +++++++++
 tb/tb_reg_file.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 32x32 integer register file with two combinational read ports, one write port and a post-reset clear sequencer.
// Optional write-through forwarding is compiled in with the RF_BYPASS_EN macro.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  reg_write,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic                  wr_en;

    // Entry 0 is hardwired zero, so it has no storage.
    logic [DATA_WIDTH-1:0] mem [1:DEPTH-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: a default assignment first keeps this combinational block from inferring a latch.
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_ptr == LAST_PTR) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    // Termination is the compare against LAST_PTR above, never the wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr <= ADDR_WIDTH'(1);
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
        end
    end

    assign wr_en = (state == RUN) && reg_write && (rd_addr != '0);

    // NOTE: the array has no reset branch; the clear sequencer zeroes it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_en) begin
                mem[rd_addr] <= rd_data;
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] value;
        if (busy || addr == '0) begin
            value = '0;
`ifdef RF_BYPASS_EN
        end else if (wr_en && rd_addr == addr) begin
            value = rd_data;
`endif
        end else begin
            value = mem[addr];
        end
        return value;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

endmodule

// File: tb/tb_reg_file.sv
// Randomized scoreboard bench for reg_file: the driver queues expected read/busy values from a
// behavioural array model, and a negedge monitor pops and compares against the DUT outputs.
module tb_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1_addr, rs2_addr, rd_addr;
    logic [DW-1:0] rs1_data, rs2_data, rd_data;
    logic          reg_write;
    logic          busy;

    reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .reg_write (reg_write),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic          busy;
        logic [DW-1:0] rs1;
        logic [DW-1:0] rs2;
    } expect_t;

    expect_t sb[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: the architectural view of the register file.
    logic [DW-1:0] model_mem [DEPTH];
    int            clear_left = 0;
    bit            known      = 0;

    task automatic check(input string name, input int c, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", name, c, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr, input logic we,
                                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (clear_left > 0 || addr == 0) return '0;
`ifdef RF_BYPASS_EN
        if (we && wa != 0 && wa == addr) return wd;
`endif
        return model_mem[addr];
    endfunction

    // Drive one cycle: inputs settle just after a rising edge, expectations are queued, then the
    // model advances on the following edge.
    task automatic step(input logic r, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        expect_t e;
        rst = r; rs1_addr = a1; rs2_addr = a2; reg_write = we; rd_addr = wa; rd_data = wd;
        if (known) begin
            e.cyc  = cyc;
            e.busy = (clear_left > 0);
            e.rs1  = model_read(a1, we, wa, wd);
            e.rs2  = model_read(a2, we, wa, wd);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            known      = 1;
            clear_left = DEPTH - 1;
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        end else if (clear_left > 0) begin
            clear_left--;
        end else if (we && wa != 0) begin
            model_mem[wa] = wd;
        end
    endtask

    task automatic idle_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        step(1'b0, a1, a2, 1'b0, '0, '0);
    endtask

    always @(negedge clk) begin
        expect_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("busy", e.cyc, {31'd0, busy}, {31'd0, e.busy});
            check("rs1_data", e.cyc, rs1_data, e.rs1);
            check("rs2_data", e.cyc, rs2_data, e.rs2);
        end
    end

    initial begin
        rst = 1'b1; rs1_addr = '0; rs2_addr = '0; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles, then the clear sequence with a write attempted on clear cycle 10.
        step(1'b1, 5'd5, 5'd0, 1'b0, '0, '0);
        step(1'b1, 5'd5, 5'd0, 1'b0, '0, '0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (i == 9) step(1'b0, 5'd5, 5'd3, 1'b1, 5'd3, 32'hA5A5A5A5);
            else        step(1'b0, 5'd5, 5'd3, 1'b0, '0, '0);
        end

        // Dropped clear-time write, ordinary write/read, x0 write, bypass.
        idle_read(5'd5, 5'd3);
        step(1'b0, 5'd1, 5'd2, 1'b1, 5'd7, 32'hDEADBEEF);
        idle_read(5'd7, 5'd7);
        idle_read(5'd6, 5'd8);
        step(1'b0, 5'd0, 5'd7, 1'b1, 5'd0, 32'h12345678);
        idle_read(5'd0, 5'd0);
        idle_read(5'd0, 5'd3);
        step(1'b0, 5'd9, 5'd7, 1'b1, 5'd9, 32'h0000FFFF);
        idle_read(5'd9, 5'd9);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), AW'($urandom), AW'($urandom),
                 ($urandom_range(0, 2) != 0), AW'($urandom), DW'($urandom));
        end

        // Reset on clear cycle 20 restarts the full 31-cycle clear.
        step(1'b1, 5'd31, 5'd31, 1'b0, '0, '0);
        for (int i = 0; i < 19; i++) step(1'b0, 5'd31, 5'd1, 1'b1, 5'd31, DW'($urandom));
        step(1'b1, 5'd31, 5'd31, 1'b1, 5'd31, 32'h55AA55AA);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 5'd31, 5'd30, 1'b0, '0, '0);
        idle_read(5'd31, 5'd30);
        idle_read(5'd31, 5'd1);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
